// File: rtl/alu_logic_pkg.sv
// Shared definitions for the bitwise logic unit: op encoding and the per-bit evaluator
// that both the pipeline and the ALU result-mux model use.
package alu_logic_pkg;

   typedef enum logic [2:0] {
      OP_AND   = 3'b000,
      OP_OR    = 3'b001,
      OP_XOR   = 3'b010,
      OP_NAND  = 3'b011,
      OP_NOR   = 3'b100,
      OP_XNOR  = 3'b101,
      OP_NOTA  = 3'b110,
      OP_PASSB = 3'b111
   } logic_op_t;

   // Evaluated one bit at a time so it serves every WIDTH without a width parameter.
   function automatic logic logic_eval(input logic a, input logic b, input logic_op_t op);
      logic r;
      case (op)
         OP_AND:   r = a & b;
         OP_OR:    r = a | b;
         OP_XOR:   r = a ^ b;
         OP_NAND:  r = ~(a & b);
         OP_NOR:   r = ~(a | b);
         OP_XNOR:  r = ~(a ^ b);
         OP_NOTA:  r = ~a;
         default:  r = b;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/pipe_reg_slice.sv
// One valid/ready register stage. Loads whenever it is empty or being drained,
// so a full pipeline of these sustains one item per cycle.
module pipe_reg_slice #(
   parameter int WIDTH_PAYLOAD = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [WIDTH_PAYLOAD-1:0] in_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [WIDTH_PAYLOAD-1:0] out_data
);

   logic                     valid_q, valid_d;
   logic [WIDTH_PAYLOAD-1:0] data_q,  data_d;

   always_comb begin
      in_ready = !valid_q || out_ready;
      valid_d  = valid_q;
      data_d   = data_q;
      if (in_ready) begin
         valid_d = in_valid;
         if (in_valid) begin
            data_d = in_data;
         end
      end
   end

   // Payload is cleared too so downstream outputs read as zero straight after reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign out_valid = valid_q;
   assign out_data  = data_q;

endmodule

// File: rtl/logic_unit_pipe.sv
// Two-stage pipelined bitwise logic unit with zero/parity flags.
// Define LOGIC_PIPE_POPCNT_EN to add the registered out_popcnt output.
module logic_unit_pipe
   import alu_logic_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic [2:0]       in_op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_result,
   output logic             out_zero,
   output logic             out_parity
`ifdef LOGIC_PIPE_POPCNT_EN
   ,
   output logic [$clog2(WIDTH+1)-1:0] out_popcnt
`endif
);

   localparam int PCW = $clog2(WIDTH+1);
   localparam int S1W = 2*WIDTH + 3;
`ifdef LOGIC_PIPE_POPCNT_EN
   localparam int S2W = WIDTH + 2 + PCW;
`else
   localparam int S2W = WIDTH + 2;
`endif

   logic           s1_valid, s1_ready;
   logic [S1W-1:0] s1_data;
   logic [S2W-1:0] s2_in, s2_data;

   logic [WIDTH-1:0] s1_a, s1_b, result;
   logic_op_t        s1_op;

   pipe_reg_slice #(.WIDTH_PAYLOAD(S1W)) u_s1 (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   ({in_a, in_b, in_op}),
      .out_valid (s1_valid),
      .out_ready (s1_ready),
      .out_data  (s1_data)
   );

   assign s1_a  = s1_data[2*WIDTH+2 : WIDTH+3];
   assign s1_b  = s1_data[WIDTH+2 : 3];
   assign s1_op = logic_op_t'(s1_data[2:0]);

   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      assign result[gi] = logic_eval(s1_a[gi], s1_b[gi], s1_op);
   end

`ifdef LOGIC_PIPE_POPCNT_EN
   logic [PCW-1:0] popcnt;

   always_comb begin
      popcnt = '0;
      for (int i = 0; i < WIDTH; i++) begin
         popcnt = popcnt + PCW'(result[i]);
      end
   end

   assign s2_in = {popcnt, ^result, ~|result, result};
   assign out_popcnt = s2_data[WIDTH+2 +: PCW];
`else
   assign s2_in = {^result, ~|result, result};
`endif

   // Flags ride in the S2 payload so they hold with the result under backpressure.
   pipe_reg_slice #(.WIDTH_PAYLOAD(S2W)) u_s2 (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (s1_valid),
      .in_ready  (s1_ready),
      .in_data   (s2_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (s2_data)
   );

   assign out_result = s2_data[WIDTH-1:0];
   assign out_zero   = s2_data[WIDTH];
   assign out_parity = s2_data[WIDTH+1];

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed bench for logic_unit_pipe: reset, all ops, flags, backpressure, random stream,
// mid-stream reset, and a WIDTH=1 instance.
module tb_logic_unit_pipe;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid, in_ready, out_valid, out_ready;
   logic [7:0] in_a, in_b, out_result;
   logic [2:0] in_op;
   logic       out_zero, out_parity;
`ifdef LOGIC_PIPE_POPCNT_EN
   logic [3:0] out_popcnt;
   logic [0:0] out_popcnt1;
`endif

   logic       in_valid1, in_ready1, out_valid1;
   logic [0:0] in_a1, in_b1, out_result1;
   logic [2:0] in_op1;
   logic       out_zero1, out_parity1;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   logic_unit_pipe #(.WIDTH(8)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_op(in_op),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_result(out_result), .out_zero(out_zero), .out_parity(out_parity)
`ifdef LOGIC_PIPE_POPCNT_EN
      , .out_popcnt(out_popcnt)
`endif
   );

   logic_unit_pipe #(.WIDTH(1)) dut1 (
      .clk(clk), .rst(rst),
      .in_valid(in_valid1), .in_ready(in_ready1),
      .in_a(in_a1), .in_b(in_b1), .in_op(in_op1),
      .out_valid(out_valid1), .out_ready(1'b1),
      .out_result(out_result1), .out_zero(out_zero1), .out_parity(out_parity1)
`ifdef LOGIC_PIPE_POPCNT_EN
      , .out_popcnt(out_popcnt1)
`endif
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] model(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
      case (op)
         3'd0: return a & b;
         3'd1: return a | b;
         3'd2: return a ^ b;
         3'd3: return ~(a & b);
         3'd4: return ~(a | b);
         3'd5: return ~(a ^ b);
         3'd6: return ~a;
         default: return b;
      endcase
   endfunction

   // Send one item with out_ready high and check it appears exactly two edges later.
   task automatic one(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                      input logic [7:0] er, input logic ez, input logic ep);
      @(negedge clk);
      out_ready = 1'b1; in_valid = 1'b1; in_a = a; in_b = b; in_op = op;
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      chk("one_lat_early", out_valid, 1'b0);
      @(negedge clk);
      #1;
      chk("one_valid", out_valid, 1'b1);
      chk("one_result", out_result, er);
      chk("one_zero", out_zero, ez);
      chk("one_parity", out_parity, ep);
   endtask

   // Stream n items; rnd=0 is the directed stall pattern, rnd=1 random valid/ready.
   task automatic stream(input int n, input bit rnd, input int max_cyc);
      int tx = 0;
      int rx = 0;
      int cyc = 0;
      bit saw_block = 1'b0;
      logic [7:0] exp_q[$];
      logic [7:0] a, b, e;
      logic [2:0] op;
      while (rx < n && cyc < max_cyc) begin
         @(negedge clk);
         out_ready = rnd ? 1'($urandom_range(0, 1)) : !(cyc >= 3 && cyc < 8);
         if (tx < n && (!rnd || $urandom_range(0, 1) == 1)) begin
            if (rnd) begin
               a = 8'($urandom); b = 8'($urandom); op = 3'($urandom_range(0, 7));
            end else begin
               a = 8'(tx); b = 8'h00; op = 3'd1;
            end
            in_valid = 1'b1; in_a = a; in_b = b; in_op = op;
         end else begin
            in_valid = 1'b0;
         end
         #1;
         chk("str_in_ready", in_ready, !((tx - rx) == 2 && !out_ready));
         if (!in_ready) saw_block = 1'b1;
         if (out_valid) begin
            if (exp_q.size() == 0) begin
               chk("str_spurious", 1'b1, 1'b0);
            end else begin
               e = exp_q[0];
               chk("str_result", out_result, e);
               chk("str_zero", out_zero, e == 8'h00);
               chk("str_parity", out_parity, ^e);
               if (out_ready) begin
                  void'(exp_q.pop_front());
                  rx++;
               end
            end
         end
         if (in_valid && in_ready) begin
            exp_q.push_back(model(a, b, op));
            tx++;
         end
         cyc++;
      end
      in_valid = 1'b0;
      chk("str_drained", rx, n);
      if (!rnd) chk("str_blocked", saw_block, 1'b1);
   endtask

   initial begin
      logic [7:0] exp_r [8] = '{8'h00, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h3A, 8'h3A};
      logic       exp_z [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      logic       exp_1 [8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
`ifdef LOGIC_PIPE_POPCNT_EN
      logic [3:0] exp_pc [8] = '{4'd0, 4'd8, 4'd8, 4'd8, 4'd0, 4'd0, 4'd4, 4'd4};
`endif

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      in_a = '0; in_b = '0; in_op = '0;
      in_valid1 = 1'b0; in_a1 = '0; in_b1 = '0; in_op1 = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst_in_ready", in_ready, 1'b1);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_result", out_result, 8'h00);
      chk("rst_zero", out_zero, 1'b0);
      chk("rst_parity", out_parity, 1'b0);

      // All eight ops back to back, A=C5 B=3A; WIDTH=1 unit runs A=1 B=0 alongside.
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         out_ready = 1'b1;
         in_valid  = (k < 8);
         in_valid1 = (k < 8);
         in_a = 8'hC5; in_b = 8'h3A; in_op = 3'(k);
         in_a1 = 1'b1; in_b1 = 1'b0; in_op1 = 3'(k);
         #1;
         chk("ops_in_ready", in_ready, 1'b1);
         if (k < 2) begin
            chk("ops_lat_early", out_valid, 1'b0);
         end else begin
            chk("ops_valid", out_valid, 1'b1);
            chk("ops_result", out_result, exp_r[k-2]);
            chk("ops_zero", out_zero, exp_z[k-2]);
            chk("ops_parity", out_parity, 1'b0);
`ifdef LOGIC_PIPE_POPCNT_EN
            chk("ops_popcnt", out_popcnt, exp_pc[k-2]);
`endif
            chk("w1_valid", out_valid1, 1'b1);
            chk("w1_result", out_result1, exp_1[k-2]);
            chk("w1_zero", out_zero1, !exp_1[k-2]);
            chk("w1_parity", out_parity1, exp_1[k-2]);
         end
      end
      in_valid1 = 1'b0;

      one(8'hF0, 8'hF0, 3'd2, 8'h00, 1'b1, 1'b0);
      one(8'h01, 8'h00, 3'd2, 8'h01, 1'b0, 1'b1);
      one(8'h7F, 8'h55, 3'd6, 8'h80, 1'b0, 1'b1);
      one(8'h12, 8'hA7, 3'd7, 8'hA7, 1'b0, 1'b1);

      stream(16, 1'b0, 100);
      stream(10000, 1'b1, 60000);

      // Fill both stages under backpressure, then reset mid-stream.
      @(negedge clk);
      out_ready = 1'b0; in_valid = 1'b1; in_a = 8'h0F; in_b = 8'h00; in_op = 3'd1;
      @(negedge clk);
      in_a = 8'h33;
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      chk("full_out_valid", out_valid, 1'b1);
      chk("full_in_ready", in_ready, 1'b0);
      chk("full_result", out_result, 8'h0F);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("mrst_out_valid", out_valid, 1'b0);
      chk("mrst_result", out_result, 8'h00);
      chk("mrst_zero", out_zero, 1'b0);
      chk("mrst_parity", out_parity, 1'b0);
      chk("mrst_in_ready", in_ready, 1'b1);
      @(negedge clk);
      #1;
      chk("mrst_no_ghost", out_valid, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog timeout CHECKS %0d ERRORS %0d", checks, errors + 1);
      $fatal(1, "timeout");
   end

endmodule
